// File: rtl/izh_pkg.sv
// Shared constants and helpers for the izh neuron family.
// Current width is common to izh and izh_synapse.
package izh_pkg;

    localparam int         IZH_CUR_W   = 8;
    localparam logic [7:0] IZH_CUR_MAX = 8'hFF;

    // Unsigned add that clamps at IZH_CUR_MAX instead of wrapping
    function automatic logic [IZH_CUR_W-1:0] sat_add(
        input logic [IZH_CUR_W-1:0] a,
        input logic [IZH_CUR_W-1:0] b
    );
        logic [IZH_CUR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[IZH_CUR_W] ? IZH_CUR_MAX : s[IZH_CUR_W-1:0];
    endfunction

endpackage

// File: rtl/izh_tick_gen.sv
// Free-running prescaler emitting a one-cycle tick every DIV clocks.
// The tick is high while the count sits at DIV-1.
module izh_tick_gen #(
    parameter int DIV = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/izh_synapse.sv
// Spike-to-current converter: each spike adds a weight, the current
// decays exponentially on prescaler ticks.
module izh_synapse
    import izh_pkg::*;
#(
    parameter int         TICK_DIV    = 16,
    parameter int         TAU_SHIFT   = 3,
    parameter logic [7:0] WEIGHT_INIT = 8'd32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spike_in,
    input  logic [7:0]           weight_in,
    input  logic                 weight_we,
    output logic [IZH_CUR_W-1:0] current,
    output logic                 active,
    output logic [7:0]           spike_count
);

    logic                 r_spike_d;
    logic [7:0]           r_weight;
    logic [IZH_CUR_W-1:0] r_cur;
    logic                 r_active;
    logic [7:0]           r_cnt;

    logic                 w_tick;
    logic                 w_event;
    logic [IZH_CUR_W-1:0] w_shift;
    logic [IZH_CUR_W-1:0] w_dec;
    logic [IZH_CUR_W-1:0] w_add;
    logic [IZH_CUR_W-1:0] w_next;

    izh_tick_gen #(
        .DIV    (TICK_DIV)
    ) u_tick (
        .i_clk  (clk),
        .i_rst  (reset),
        .o_tick (w_tick)
    );

    assign w_event = spike_in & ~r_spike_d;
    assign w_shift = r_cur >> TAU_SHIFT;

    // Decay step is at least 1 so the tail always reaches zero
    always_comb begin
        w_dec = '0;
        if (w_tick && r_cur != '0) begin
            w_dec = (w_shift == '0) ? IZH_CUR_W'(1) : w_shift;
        end
    end

    assign w_add  = w_event ? r_weight : '0;
    assign w_next = sat_add(r_cur - w_dec, w_add);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spike_d <= 1'b0;
            r_weight  <= WEIGHT_INIT;
            r_cur     <= '0;
            r_active  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_spike_d <= spike_in;
            r_cur     <= w_next;
            r_active  <= (w_next != '0);
            r_cnt     <= r_cnt + {7'd0, w_event};
            if (weight_we) begin
                r_weight <= weight_in;
            end
        end
    end

    assign current     = r_cur;
    assign active      = r_active;
    assign spike_count = r_cnt;

endmodule
